// File: rtl/vanilla_exe_bubble_classifier_pkg.sv
// Shared types for the EXE bubble classification stream.
// Defines bubble type codes and the default run record layout.
package vanilla_exe_bubble_classifier_pkg;

  localparam int exe_pc_width_gp  = 24;
  localparam int exe_run_width_gp = 16;

  typedef enum logic [31:0] {
    e_exe_no_bubble    = 32'd0,
    e_exe_branch_miss  = 32'd1,
    e_exe_icache_miss  = 32'd2,
    e_exe_fdiv_busy    = 32'd3,
    e_exe_dcache_miss  = 32'd4,
    e_exe_idiv_busy    = 32'd5,
    e_exe_barrier      = 32'd6
  } exe_bubble_type_e;

  typedef struct packed {
    exe_bubble_type_e              btype;
    logic [exe_pc_width_gp-1:0]    pc;
    logic [exe_run_width_gp-1:0]   len;
  } vanilla_exe_bubble_record_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1-read/1-write FIFO, valid/ready in, valid/yumi out.
// Ports: clk_i, reset_n_i (sync, low), v_i/data_i/ready_o, v_o/data_o/yumi_i.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int aw_lp = $clog2(els_p);

  logic [width_p-1:0] mem_q [els_p];
  logic [aw_lp:0]     wptr_q, wptr_d;
  logic [aw_lp:0]     rptr_q, rptr_d;
  logic               full, empty, push, pop;

  // extra pointer bit tells full from empty
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[aw_lp] != rptr_q[aw_lp])
               & (wptr_q[aw_lp-1:0] == rptr_q[aw_lp-1:0]);

  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_q[rptr_q[aw_lp-1:0]];

  assign push = v_i & ~full;
  assign pop  = yumi_i & ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[aw_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/vanilla_exe_bubble_profiler.sv
// EXE bubble profiler: per-type saturating counters plus run-length
// records of identical bubbles, buffered for a valid/ready consumer.
// Ports: clk_i, reset_n_i, en_i, stall_all_i, exe_bubble_type_i/pc_i,
// clear_i, cnt_sel_i/cnt_o, rec_v_o/rec_ready_i/rec_o, drop_cnt_o, err_o.
module vanilla_exe_bubble_profiler
  import vanilla_exe_bubble_classifier_pkg::*;
#(
  parameter int pc_width_p      = 24,
  parameter int num_types_p     = 32,
  parameter int counter_width_p = 32,
  parameter int run_width_p     = 16,
  parameter int fifo_els_p      = 4,
  localparam int sel_w_lp       = $clog2(num_types_p),
  localparam int rec_w_lp       = 32 + pc_width_p + run_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       en_i,
  input  logic                       stall_all_i,
  input  logic [31:0]                exe_bubble_type_i,
  input  logic [pc_width_p-1:0]      exe_bubble_pc_i,
  input  logic                       clear_i,
  input  logic [sel_w_lp-1:0]        cnt_sel_i,
  output logic [counter_width_p-1:0] cnt_o,
  output logic                       rec_v_o,
  input  logic                       rec_ready_i,
  output logic [rec_w_lp-1:0]        rec_o,
  output logic [counter_width_p-1:0] drop_cnt_o,
  output logic                       err_o
);

  typedef struct packed {
    logic [31:0]             btype;
    logic [pc_width_p-1:0]   pc;
    logic [run_width_p-1:0]  len;
  } rec_t;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            type_q, type_d;
  logic [pc_width_p-1:0]  pc_q, pc_d;
  logic [run_width_p-1:0] len_q, len_d;

  // padded to a power of two; unused slots never count
  logic [counter_width_p-1:0] cnt_q [2**sel_w_lp];
  logic [counter_width_p-1:0] drop_q;
  logic                       err_q;

  logic       acc, inv, bubble, same, close;
  logic       fifo_ready;
  rec_t       push_rec;
  logic [sel_w_lp-1:0] idx;

  assign acc    = en_i & ~stall_all_i;
  assign inv    = exe_bubble_type_i >= 32'(num_types_p);
  // invalid codes behave as no_bubble for run tracking
  assign bubble = ~inv
                & (exe_bubble_type_i != 32'(e_exe_no_bubble));
  assign same   = (exe_bubble_type_i == type_q)
                & (exe_bubble_pc_i == pc_q);
  assign idx    = exe_bubble_type_i[sel_w_lp-1:0];

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    pc_d    = pc_q;
    len_d   = len_q;
    close   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc & bubble) begin
          state_d = RUN;
          type_d  = exe_bubble_type_i;
          pc_d    = exe_bubble_pc_i;
          len_d   = run_width_p'(1);
        end
      end
      RUN: begin
        if (!en_i) begin
          close   = 1'b1;
          state_d = IDLE;
        end else if (acc) begin
          if (!bubble) begin
            close   = 1'b1;
            state_d = IDLE;
          end else if (same & ~&len_q) begin
            len_d = len_q + 1'b1;
          end else begin
            close  = 1'b1;
            type_d = exe_bubble_type_i;
            pc_d   = exe_bubble_pc_i;
            len_d  = run_width_p'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      type_q  <= '0;
      pc_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 2**sel_w_lp; i++) cnt_q[i] <= '0;
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (acc & inv) err_q <= 1'b1;
      if (clear_i) begin
        for (int i = 0; i < 2**sel_w_lp; i++) cnt_q[i] <= '0;
        drop_q <= '0;
      end else begin
        if (acc & ~inv & ~&cnt_q[idx])
          cnt_q[idx] <= cnt_q[idx] + 1'b1;
        if (close & ~fifo_ready & ~&drop_q)
          drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign push_rec.btype = type_q;
  assign push_rec.pc    = pc_q;
  assign push_rec.len   = len_q;

  bsg_fifo_1r1w_small #(
    .width_p (rec_w_lp),
    .els_p   (fifo_els_p)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (close),
    .data_i    (push_rec),
    .ready_o   (fifo_ready),
    .v_o       (rec_v_o),
    .data_o    (rec_o),
    .yumi_i    (rec_ready_i)
  );

  assign cnt_o      = cnt_q[cnt_sel_i];
  assign drop_cnt_o = drop_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_vanilla_exe_bubble_profiler.sv
// Directed bench for vanilla_exe_bubble_profiler.
// Runs short run-length scenarios and checks records and counters.
module tb_vanilla_exe_bubble_profiler;
  import vanilla_exe_bubble_classifier_pkg::*;

  localparam int PCW = 24;
  localparam int RW  = 4;
  localparam int CW  = 32;
  localparam int RECW = 32 + PCW + RW;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            en = 1'b0;
  logic            stall = 1'b0;
  logic [31:0]     btype = '0;
  logic [PCW-1:0]  bpc = '0;
  logic            clear = 1'b0;
  logic [4:0]      sel = '0;
  logic [CW-1:0]   cnt;
  logic            rec_v;
  logic            rec_ready = 1'b0;
  logic [RECW-1:0] rec;
  logic [CW-1:0]   drop;
  logic            err;

  int n_chk = 0;
  int n_err = 0;

  vanilla_exe_bubble_profiler #(
    .pc_width_p      (PCW),
    .num_types_p     (32),
    .counter_width_p (CW),
    .run_width_p     (RW),
    .fifo_els_p      (4)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .en_i              (en),
    .stall_all_i       (stall),
    .exe_bubble_type_i (btype),
    .exe_bubble_pc_i   (bpc),
    .clear_i           (clear),
    .cnt_sel_i         (sel),
    .cnt_o             (cnt),
    .rec_v_o           (rec_v),
    .rec_ready_i       (rec_ready),
    .rec_o             (rec),
    .drop_cnt_o        (drop),
    .err_o             (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_cnt(input string tag, input int s,
                         input logic [CW-1:0] exp);
    sel = 5'(s);
    #1;
    check(tag, 64'(cnt), 64'(exp));
  endtask

  task automatic sample(input logic [31:0] t, input int pc, input int n);
    btype = t;
    bpc   = PCW'(pc);
    steps(n);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  function automatic logic [RECW-1:0] mk(input logic [31:0] t,
                                         input int pc, input int len);
    return {t, PCW'(pc), RW'(len)};
  endfunction

  task automatic drain(input string tag, input logic [RECW-1:0] exp);
    check({tag, "_v"}, 64'(rec_v), 64'(1));
    check(tag, 64'(rec), 64'(exp));
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
  endtask

  initial begin
    // reset
    steps(2);
    reset_n = 1'b1;
    chk_cnt("rst_cnt", 0, 0);
    check("rst_v", 64'(rec_v), 0);
    check("rst_drop", 64'(drop), 0);
    check("rst_err", 64'(err), 0);

    // branch_miss run of 5
    en = 1'b1;
    sample(e_exe_branch_miss, 'h100, 5);
    check("t1_noclose_v", 64'(rec_v), 0);
    sample(e_exe_no_bubble, 0, 1);
    en = 1'b0;
    chk_cnt("t1_cnt_bm", 1, 5);
    chk_cnt("t1_cnt_nb", 0, 1);
    drain("t1_rec", mk(e_exe_branch_miss, 'h100, 5));
    check("t1_empty", 64'(rec_v), 0);

    // icache_miss with PC change
    do_clear();
    en = 1'b1;
    sample(e_exe_icache_miss, 'h200, 3);
    sample(e_exe_icache_miss, 'h204, 2);
    sample(e_exe_no_bubble, 0, 1);
    en = 1'b0;
    chk_cnt("t2_cnt_ic", 2, 5);
    drain("t2_rec0", mk(e_exe_icache_miss, 'h200, 3));
    drain("t2_rec1", mk(e_exe_icache_miss, 'h204, 2));

    // stall inside fdiv run
    do_clear();
    en = 1'b1;
    sample(e_exe_fdiv_busy, 'h300, 2);
    stall = 1'b1;
    steps(10);
    check("t3_stall_v", 64'(rec_v), 0);
    stall = 1'b0;
    sample(e_exe_fdiv_busy, 'h300, 2);
    sample(e_exe_no_bubble, 0, 1);
    en = 1'b0;
    chk_cnt("t3_cnt_fd", 3, 4);
    drain("t3_rec", mk(e_exe_fdiv_busy, 'h300, 4));

    // run length saturation at 15
    do_clear();
    en = 1'b1;
    sample(e_exe_dcache_miss, 'h400, 20);
    sample(e_exe_no_bubble, 0, 1);
    en = 1'b0;
    chk_cnt("t4_cnt_dc", 4, 20);
    drain("t4_rec0", mk(e_exe_dcache_miss, 'h400, 15));
    drain("t4_rec1", mk(e_exe_dcache_miss, 'h400, 5));

    // FIFO overflow with consumer stalled
    en = 1'b1;
    for (int i = 1; i <= 6; i++) sample(32'(i), 'h500 + i, 1);
    sample(e_exe_no_bubble, 0, 1);
    en = 1'b0;
    check("t5_drop", 64'(drop), 2);
    for (int i = 1; i <= 4; i++)
      drain($sformatf("t5_rec%0d", i), mk(32'(i), 'h500 + i, 1));
    check("t5_empty", 64'(rec_v), 0);

    // invalid type
    do_clear();
    en = 1'b1;
    sample(32'd40, 'h600, 1);
    en = 1'b0;
    check("t6_err", 64'(err), 1);
    chk_cnt("t6_cnt0", 0, 0);
    chk_cnt("t6_cnt8", 8, 0);
    step();
    check("t6_norec", 64'(rec_v), 0);

    // clear wins over a same-cycle sample
    en = 1'b1;
    sample(e_exe_branch_miss, 'h700, 2);
    chk_cnt("t7_pre", 1, 2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    en = 1'b0;
    chk_cnt("t7_cnt", 1, 0);
    check("t7_err_kept", 64'(err), 1);

    // reset mid-run discards open run
    en = 1'b1;
    sample(e_exe_branch_miss, 'h700, 2);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    en = 1'b0;
    step();
    check("t8_v", 64'(rec_v), 0);
    check("t8_err", 64'(err), 0);
    check("t8_drop", 64'(drop), 0);
    chk_cnt("t8_cnt", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vanilla_exe_bubble_profiler.md
Name: vanilla_exe_bubble_profiler

Overview:
- Consumer end of the EXE bubble classification stream. Samples the per-cycle bubble type/PC produced for the EXE stage.
- Keeps a saturating cycle counter for each bubble type.
- Run-length encodes consecutive identical bubbles (same type and PC) into records. Records are buffered in a small FIFO and drained by the testbench trace writer over a valid/ready interface.
- Instantiated once per tile in the testbench, alongside the core profilers.

Parameters:
- pc_width_p, 24, width of bubble PC input and record PC field
- num_types_p, 32, number of per-type counters; type codes >= num_types_p are invalid
- counter_width_p, 32, width of each per-type counter
- run_width_p, 16, width of the record run-length field
- fifo_els_p, 4, record FIFO depth (power of two, >= 2)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, synchronous, active-low
- en_i  in  1  profiling enable
- stall_all_i  in  1  pipeline-wide stall; EXE bubble info is held, not new
- exe_bubble_type_i  in  32  bubble type code (exe_bubble_type_e)
- exe_bubble_pc_i  in  pc_width_p  PC charged for the bubble
- clear_i  in  1  zero all per-type counters and the drop counter
- cnt_sel_i  in  $clog2(num_types_p)  counter read select
- cnt_o  out  counter_width_p  value of counter[cnt_sel_i], combinational read of registers
- rec_v_o  out  1  record valid
- rec_ready_i  in  1  record consumer ready
- rec_o  out  struct  {type 32, pc pc_width_p, len run_width_p}
- drop_cnt_o  out  counter_width_p  records lost to a full FIFO, saturating
- err_o  out  1  sticky: invalid type code accepted

Behaviour:
- Reset (reset_n_i==0 at clk edge): all counters = 0, drop_cnt_o = 0, err_o = 0, FIFO empty (rec_v_o = 0), FSM = IDLE. Reset mid-run discards the open run; no record is emitted.
- Accepted sample: en_i & ~stall_all_i. Non-accepted cycles change neither counters nor FSM, except the en_i flush below.
- Counting, for each accepted sample with type < num_types_p:
  - counter[type] += 1, saturating at all-ones.
  - e_exe_no_bubble is counted too, so total accepted cycles = sum of counters.
- Invalid type: type >= num_types_p sets err_o; no counter increments; for run encoding it is treated as no_bubble.
- clear_i has priority over an increment in the same cycle; that sample is not counted. clear_i does not affect the FSM, the FIFO, or err_o.
- Run FSM:
  - IDLE, accepted bubble (type != no_bubble) -> RUN; open run = {type, pc}, len = 1.
  - RUN, accepted sample with same type and pc and len < 2^run_width_p-1 -> len += 1.
  - RUN, accepted bubble that differs, or len saturated -> close the current run, open a new one with len = 1; stay in RUN.
  - RUN, accepted no_bubble -> close the run; go to IDLE.
  - RUN, en_i==0 -> close the run in that cycle; go to IDLE. No close occurs while stall_all_i is high and en_i is high.
- Close: push the record into the FIFO if it is not full; if full, drop the record and drop_cnt_o += 1 (saturating). The FIFO has no pass-through, so fullness is judged before this cycle's pop.
- Latency: a closed record appears on rec_v_o on the cycle after the close at the earliest.
- Output handshake: a record leaves when rec_v_o & rec_ready_i. rec_o stays stable while rec_v_o=1 and rec_ready_i=0.
- FIFO wrap-around follows the standard small-FIFO pointer behaviour. Back-to-back push and pop while non-full is allowed every cycle.

Decomposition:
- Add vanilla_exe_bubble_record_s {type, pc, len} to vanilla_exe_bubble_classifier_pkg. The struct is parameterised by package-level widths; the module uses localparam-sized fields consistent with the parameters.
- exe_bubble_type_e (including e_exe_no_bubble) comes from the same package.
- Record buffer sub-module: bsg_fifo_1r1w_small (els_p = fifo_els_p).
- Counters and FSM are inline.

Test Plan:
- 5 accepted cycles of branch_miss @pc 0x100, then no_bubble -> one record {branch_miss, 0x100, 5}; counter[branch_miss]=5; counter[no_bubble]=1.
- icache_miss @0x200 x3, then icache_miss @0x204 x2, then no_bubble -> records {icache_miss, 0x200, 3}, {icache_miss, 0x204, 2}, in order.
- stall_all_i=1 for 10 cycles inside a 4-cycle fdiv_busy run @0x300 -> record len=4; counter[fdiv_busy]=4.
- run_width_p=4, 20 identical bubbles -> records len 15 then len 5.
- rec_ready_i=0, 6 distinct single-cycle runs with fifo_els_p=4 -> 4 records retained, drop_cnt_o=2; raising ready drains the 4 in order.
- Type 40 (invalid) -> err_o=1, no counter changes. clear_i with a simultaneous sample -> all counters 0 next cycle. reset_n_i=0 mid-run -> no record emitted, all outputs 0.
